lc3_mem_ctrl: RTL
=================

# lc3_mem_ctrl

Initiator-side memory controller for the LC-3 datapath. Accepts single-word read/write requests from the core's MAR/MDR logic, drives the chip-select / read-write handshake of the LC-3 RAM, and waits for the RAM's registered `ready` before returning data. An optional memory-mapped I/O decoder intercepts the keyboard and display device registers so that those addresses never reach the RAM.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: word width.
- `ADDR_WIDTH`, default 16: address width.
- `TIMEOUT`, default 15: maximum number of WAIT cycles before the access aborts.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk` in 1: rising-edge clock for all state.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in ADDR_WIDTH: word address; sampled with `req`.
- `wdata` in DATA_WIDTH: write data; sampled with `req`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out DATA_WIDTH: read result, valid while `done` = 1 and held afterwards.
- `err` out 1: high with `done` when the access timed out.
- `mem_cs` out 1: RAM chip select.
- `mem_r_w` out 1: RAM write enable (1 = write).
- `mem_addr` out ADDR_WIDTH: RAM address.
- `mem_data_in` out DATA_WIDTH: RAM write data.
- `mem_ready` in 1: RAM registered ready.
- `mem_data_out` in DATA_WIDTH: RAM read data.
- `kbd_valid` in 1: keyboard character strobe (MMIO only).
- `kbd_data` in 8: keyboard character (MMIO only).
- `disp_ready` in 1: display idle (MMIO only).
- `disp_valid` out 1: one-cycle display strobe (MMIO only).
- `disp_data` out 8: display character (MMIO only).

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE with `req` = 1: latch `we`, `addr` and `wdata`, then go to ACCESS. `req` is ignored in every other state.
- ACCESS lasts one cycle: `mem_cs` = 1, `mem_r_w` = latched `we`, `mem_addr` and `mem_data_in` driven from the latches. Next state is WAIT.
- WAIT: `mem_cs` = 0 and `mem_addr` is held.
  - On `mem_ready` = 1: capture `mem_data_out` into `rdata` on reads (`rdata` is unchanged on writes), go to DONE.
  - Otherwise increment the wait counter. When the counter equals `TIMEOUT`: set `err`, set `rdata` = 0, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE. The next `req` can be accepted in the cycle after DONE.
- `mem_ready` is sampled only in WAIT, so a stale `ready` from a previous access cannot complete a new one.
- Write data read back by the RAM (read-before-write value) is discarded.
- `err` clears when the next request is accepted.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_cs`, `mem_r_w`, `disp_valid` = 0; `rdata`, `mem_addr`, `mem_data_in`, `disp_data`, wait counter = 0; keyboard flag = 0.
- `req` sampled at edge 0 → ACCESS in cycle 1 → RAM samples `cs` at edge 2 → `ready` seen in cycle 2 (WAIT) → `done` in cycle 3.
- RAM access latency is 3 cycles from request to `done`. Throughput is one access per 4 cycles.
- Reset mid-operation: the next edge returns to IDLE with `mem_cs` = 0 and no `done` pulse. A RAM write already sampled by the RAM is not undone.
- The wait counter is `$clog2(TIMEOUT+1)` bits wide and clears on entry to WAIT.

## Configuration
Macro `LC3_MMIO_EN`.

Defined:
- Requests to 0xFE00 (KBSR), 0xFE02 (KBDR), 0xFE04 (DSR) and 0xFE06 (DDR) never assert `mem_cs`. They go IDLE → DONE, so `done` appears 1 cycle after `req`.
- KBSR read returns {flag, 15'b0}.
- KBDR read returns {8'b0, kbd char} and clears the flag.
- `kbd_valid` sets the flag and loads the character. If `kbd_valid` coincides with a KBDR read, the read returns the old character and the flag stays 1.
- DSR read returns {`disp_ready`, 15'b0}.
- DDR write pulses `disp_valid` for one cycle with `disp_data` = `wdata[7:0]`.
- Writes to KBSR, KBDR and DSR, and reads of DDR, complete with `rdata` = 0 and no side effect.

Undefined:
- All addresses go to RAM.
- Keyboard and display ports are tied off: `disp_valid` = 0, `disp_data` = 0, inputs ignored.

## Test plan
- Write 0x1234 to 0x3000, then read 0x3000 → `mem_cs` asserted one cycle per access; `done` 3 cycles after each `req`; `rdata` = 0x1234, `err` = 0.
- Hold `req` = 1 continuously for a read of 0x3001 → exactly one access, and a second access accepted only after DONE; `busy` stays 1 from cycle 1 until `done`.
- Model RAM never asserts `mem_ready`, `TIMEOUT` = 15 → `done` with `err` = 1 and `rdata` = 0 after 15 WAIT cycles; the next request clears `err`.
- Assert `reset` in WAIT → IDLE next cycle, no `done`, all outputs at reset values.
- `LC3_MMIO_EN`: pulse `kbd_valid` with 0x41, read 0xFE00 → 0x8000; read 0xFE02 → 0x0041; read 0xFE00 → 0x0000; `mem_cs` never asserted.
- `LC3_MMIO_EN`: `disp_ready` = 1, read 0xFE04 → 0x8000; write 0x0058 to 0xFE06 → one-cycle `disp_valid` with `disp_data` = 0x58.

Source files
------------

// File: rtl/lc3_mem_ctrl_if.sv
// Signal bundle between the LC-3 core, lc3_mem_ctrl, the RAM and the MMIO devices.
// master = core/RAM/device side, slave = controller side.
interface lc3_mem_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  mem_cs;
    logic                  mem_r_w;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  kbd_valid;
    logic [7:0]            kbd_data;
    logic                  disp_ready;
    logic                  disp_valid;
    logic [7:0]            disp_data;

    modport master (
        output req, we, addr, wdata, mem_ready, mem_data_out, kbd_valid, kbd_data, disp_ready,
        input  busy, done, rdata, err, mem_cs, mem_r_w, mem_addr, mem_data_in, disp_valid,
               disp_data
    );

    modport slave (
        input  req, we, addr, wdata, mem_ready, mem_data_out, kbd_valid, kbd_data, disp_ready,
        output busy, done, rdata, err, mem_cs, mem_r_w, mem_addr, mem_data_in, disp_valid,
               disp_data
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 initiator-side memory controller: one RAM access per request with timeout.
// Define LC3_MMIO_EN to decode the keyboard/display registers at 0xFE00-0xFE06.
module lc3_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input logic           clk,
    input logic           reset,
    lc3_mem_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_accept;
    logic                  w_ram_done;
    logic                  w_timeout;
    logic                  w_mmio;
    logic                  w_mmio_load;
    logic [DATA_WIDTH-1:0] w_mmio_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // MMIO requests skip the RAM handshake and complete straight from IDLE.
    always_comb begin
        w_state_d  = r_state;
        w_accept   = 1'b0;
        w_ram_done = 1'b0;
        w_timeout  = 1'b0;
        w_cnt_inc  = r_cnt + CW'(1);
        unique case (r_state)
            StIdle: begin
                if (bus.req) begin
                    w_accept  = 1'b1;
                    w_state_d = w_mmio ? StDone : StAccess;
                end
            end
            StAccess: w_state_d = StWait;
            StWait: begin
                if (bus.mem_ready) begin
                    w_ram_done = 1'b1;
                    w_state_d  = StDone;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_err   <= 1'b0;
            end
            if (w_accept && w_mmio_load) begin
                r_rdata <= w_mmio_rdata;
            end
            if (r_state == StAccess) begin
                r_cnt <= '0;
            end else if (r_state == StWait && !bus.mem_ready) begin
                r_cnt <= w_cnt_inc;
            end
            // The RAM's read-before-write data is dropped on writes.
            if (w_ram_done && !r_we) begin
                r_rdata <= bus.mem_data_out;
            end
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

    assign bus.busy        = (r_state != StIdle);
    assign bus.done        = (r_state == StDone);
    assign bus.rdata       = r_rdata;
    assign bus.err         = r_err;
    assign bus.mem_cs      = (r_state == StAccess);
    assign bus.mem_r_w     = (r_state == StAccess) & r_we;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_data_in = r_wdata;

`ifdef LC3_MMIO_EN
    localparam logic [ADDR_WIDTH-1:0] KbsrAddr = ADDR_WIDTH'(32'hFE00);
    localparam logic [ADDR_WIDTH-1:0] KbdrAddr = ADDR_WIDTH'(32'hFE02);
    localparam logic [ADDR_WIDTH-1:0] DsrAddr  = ADDR_WIDTH'(32'hFE04);
    localparam logic [ADDR_WIDTH-1:0] DdrAddr  = ADDR_WIDTH'(32'hFE06);

    logic       r_kbd_flag;
    logic [7:0] r_kbd_char;
    logic       r_disp_valid;
    logic [7:0] r_disp_data;
    logic       w_kbsr;
    logic       w_kbdr;
    logic       w_dsr;
    logic       w_ddr;

    assign w_kbsr      = (bus.addr == KbsrAddr);
    assign w_kbdr      = (bus.addr == KbdrAddr);
    assign w_dsr       = (bus.addr == DsrAddr);
    assign w_ddr       = (bus.addr == DdrAddr);
    assign w_mmio      = w_kbsr | w_kbdr | w_dsr | w_ddr;
    assign w_mmio_load = w_mmio & ~(w_ddr & bus.we);

    always_comb begin
        w_mmio_rdata = '0;
        if (!bus.we) begin
            if (w_kbsr) begin
                w_mmio_rdata[DATA_WIDTH-1] = r_kbd_flag;
            end else if (w_kbdr) begin
                w_mmio_rdata[7:0] = r_kbd_char;
            end else if (w_dsr) begin
                w_mmio_rdata[DATA_WIDTH-1] = bus.disp_ready;
            end
        end
    end

    // A new character wins over a coincident KBDR read, so the flag stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd_flag   <= 1'b0;
            r_kbd_char   <= '0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_disp_valid <= 1'b0;
            if (bus.kbd_valid) begin
                r_kbd_flag <= 1'b1;
                r_kbd_char <= bus.kbd_data;
            end else if (w_accept && w_kbdr && !bus.we) begin
                r_kbd_flag <= 1'b0;
            end
            if (w_accept && w_ddr && bus.we) begin
                r_disp_valid <= 1'b1;
                r_disp_data  <= bus.wdata[7:0];
            end
        end
    end

    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_data  = r_disp_data;
`else
    logic w_unused;

    assign w_mmio         = 1'b0;
    assign w_mmio_load    = 1'b0;
    assign w_mmio_rdata   = '0;
    assign bus.disp_valid = 1'b0;
    assign bus.disp_data  = '0;
    assign w_unused       = ^{bus.kbd_valid, bus.kbd_data, bus.disp_ready};
`endif
endmodule
